// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/issue stage: RV32I opcodes, execution-unit
// control encodings, the issue-slot state and the decoded control bundle.
package decode_issue_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALUOP_R      = 3'b000;
    localparam logic [2:0] ALUOP_I      = 3'b001;
    localparam logic [2:0] ALUOP_BRANCH = 3'b010;
    localparam logic [2:0] ALUOP_JUMP   = 3'b011;
    localparam logic [2:0] ALUOP_LOAD   = 3'b100;
    localparam logic [2:0] ALUOP_STORE  = 3'b101;
    localparam logic [2:0] ALUOP_UPPER  = 3'b110;

    localparam logic [1:0] ASRC_REG = 2'b00;
    localparam logic [1:0] ASRC_PC  = 2'b01;
    localparam logic [1:0] ASRC_PC4 = 2'b10;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_LOAD = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [2:0] aluOp;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [1:0] aSrc;
        logic       bSrc;
        logic       branchOp;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
    } ctrl_t;

    function automatic logic usesRs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_BRANCH) || (op == OP_STORE) ||
               (op == OP_I) || (op == OP_LOAD)   || (op == OP_JALR);
    endfunction

    function automatic logic usesRs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_BRANCH) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/decode_issue_imm.sv
// Immediate generator: picks the I/S/B/U/J immediate by opcode and sign-extends
// it to the operand width.
module imm_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           inst_i,
    output logic [DATA_WIDTH-1:0] imm_o
);
    import decode_issue_pkg::*;

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (inst_i[6:0])
            OP_I, OP_LOAD, OP_JALR: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            OP_STORE:               imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OP_BRANCH:              imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                             inst_i[30:25], inst_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:       imm32 = {inst_i[31:12], 12'b0};
            OP_JAL:                 imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                             inst_i[20], inst_i[30:21], 1'b0};
            default:                imm32 = '0;
        endcase
    end

    assign imm_o = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: decodes fetched RV32I words into execution-unit
// controls and holds them in a one-entry issue slot with stall/flush/load-use handling.
module decode_issue #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inst_valid,
    input  logic [31:0]             inst,
    input  logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    inst_ready,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    input  logic [DATA_WIDTH-1:0]   rs1_data,
    input  logic [DATA_WIDTH-1:0]   rs2_data,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [2:0]              ALU_Operation,
    output logic [2:0]              funct3,
    output logic [6:0]              funct7,
    output logic [1:0]              ALU_ASrc,
    output logic                    ALU_BSrc,
    output logic                    branch_op,
    output logic [DATA_WIDTH-1:0]   regRead_1,
    output logic [DATA_WIDTH-1:0]   regRead_2,
    output logic [DATA_WIDTH-1:0]   extend,
    output logic [ADDRESS_BITS-1:0] PC,
    output logic [4:0]              rd,
    output logic                    regWrite,
    output logic                    memRead,
    output logic                    memWrite,
    input  logic                    flush,
    output logic                    illegal,
    output logic [31:0]             issued_count,
    input  logic                    report
);
    import decode_issue_pkg::*;

    logic [6:0]              opcode;
    ctrl_t                   decCtrl;
    logic                    decIllegal;
    logic [DATA_WIDTH-1:0]   immValue;
    logic                    hazard;
    logic                    accept;
    logic                    issueFire;
    logic                    loadSlot;

    slot_state_e             state_q, state_d;
    ctrl_t                   ctrl_q;
    logic [DATA_WIDTH-1:0]   op1_q, op2_q, ext_q;
    logic [ADDRESS_BITS-1:0] pc_q;
    logic                    illegal_q;
    logic [31:0]             count_q;

    // The report dump is a simulation aid only; it has no hardware behaviour.
    logic unusedInputs;
    assign unusedInputs = report ^ (CORE != 0);

    assign opcode   = inst[6:0];
    assign rs1_addr = (opcode == OP_LUI) ? 5'd0 : inst[19:15];
    assign rs2_addr = inst[24:20];

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .inst_i (inst),
        .imm_o  (immValue)
    );

    always_comb begin
        decCtrl        = '0;
        decIllegal     = 1'b0;
        decCtrl.funct3 = inst[14:12];
        decCtrl.rd     = inst[11:7];
        case (opcode)
            OP_R: begin
                decCtrl.aluOp    = ALUOP_R;
                decCtrl.funct7   = inst[31:25];
                decCtrl.regWrite = 1'b1;
            end
            OP_I: begin
                decCtrl.aluOp    = ALUOP_I;
                decCtrl.bSrc     = 1'b1;
                decCtrl.regWrite = 1'b1;
                // Right shifts carry the arithmetic/logical select in funct7.
                if (inst[14:12] == 3'b101) begin
                    decCtrl.funct7 = inst[31:25];
                end
            end
            OP_LOAD: begin
                decCtrl.aluOp    = ALUOP_LOAD;
                decCtrl.bSrc     = 1'b1;
                decCtrl.regWrite = 1'b1;
                decCtrl.memRead  = 1'b1;
            end
            OP_STORE: begin
                decCtrl.aluOp    = ALUOP_STORE;
                decCtrl.bSrc     = 1'b1;
                decCtrl.memWrite = 1'b1;
                decCtrl.rd       = 5'd0;
            end
            OP_BRANCH: begin
                decCtrl.aluOp    = ALUOP_BRANCH;
                decCtrl.branchOp = 1'b1;
                decCtrl.rd       = 5'd0;
            end
            OP_JAL, OP_JALR: begin
                decCtrl.aluOp    = ALUOP_JUMP;
                decCtrl.aSrc     = ASRC_PC4;
                decCtrl.bSrc     = 1'b1;
                decCtrl.regWrite = 1'b1;
            end
            OP_LUI: begin
                decCtrl.aluOp    = ALUOP_UPPER;
                decCtrl.bSrc     = 1'b1;
                decCtrl.regWrite = 1'b1;
            end
            OP_AUIPC: begin
                decCtrl.aluOp    = ALUOP_UPPER;
                decCtrl.aSrc     = ASRC_PC;
                decCtrl.bSrc     = 1'b1;
                decCtrl.regWrite = 1'b1;
            end
            default: begin
                decCtrl       = '0;
                decCtrl.aluOp = ALUOP_I;
                decIllegal    = 1'b1;
            end
        endcase
        if (decCtrl.rd == 5'd0) begin
            decCtrl.regWrite = 1'b0;
        end
    end

    // A load in the slot blocks any incoming word that reads its destination.
    assign hazard = (state_q == FULL_LOAD) &&
                    ((usesRs1(opcode) && (inst[19:15] == ctrl_q.rd)) ||
                     (usesRs2(opcode) && (inst[24:20] == ctrl_q.rd)));

    assign inst_ready = !reset && !hazard && ((state_q == EMPTY) || issue_ready);
    assign accept     = inst_valid && inst_ready;
    assign issueFire  = issue_valid && issue_ready;
    assign loadSlot   = accept && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = ((opcode == OP_LOAD) && (decCtrl.rd != 5'd0)) ? FULL_LOAD : FULL;
        end else if (issueFire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= EMPTY;
            ctrl_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            ext_q     <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= loadSlot && decIllegal;
            if (loadSlot) begin
                ctrl_q <= decCtrl;
                // Illegal words become a clean NOP; LUI reads x0 as its A operand.
                op1_q  <= (decIllegal || (opcode == OP_LUI)) ? '0 : rs1_data;
                op2_q  <= decIllegal ? '0 : rs2_data;
                ext_q  <= decIllegal ? '0 : immValue;
                pc_q   <= decIllegal ? '0 : inst_PC;
            end
            if (issueFire) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign issue_valid   = (state_q != EMPTY);
    assign ALU_Operation = ctrl_q.aluOp;
    assign funct3        = ctrl_q.funct3;
    assign funct7        = ctrl_q.funct7;
    assign ALU_ASrc      = ctrl_q.aSrc;
    assign ALU_BSrc      = ctrl_q.bSrc;
    assign branch_op     = ctrl_q.branchOp;
    assign rd            = ctrl_q.rd;
    assign regWrite      = ctrl_q.regWrite;
    assign memRead       = ctrl_q.memRead;
    assign memWrite      = ctrl_q.memWrite;
    assign regRead_1     = op1_q;
    assign regRead_2     = op2_q;
    assign extend        = ext_q;
    assign PC            = pc_q;
    assign illegal       = illegal_q;
    assign issued_count  = count_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: expected slot contents are queued on accept and
// compared by a monitor at each issue handshake; control-path behaviour is checked inline.
module tb_decode_issue;

    typedef struct packed {
        logic [2:0]  aluOp;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [1:0]  aSrc;
        logic        bSrc;
        logic        br;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] ext;
        logic [19:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    logic        clock, reset, inst_valid, inst_ready, issue_valid, issue_ready;
    logic [31:0] inst;
    logic [19:0] inst_PC, PC;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [31:0] rs1_data, rs2_data, regRead_1, regRead_2, extend, issued_count;
    logic [2:0]  ALU_Operation, funct3;
    logic [6:0]  funct7;
    logic [1:0]  ALU_ASrc;
    logic        ALU_BSrc, branch_op, regWrite, memRead, memWrite, flush, illegal, report;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    decode_issue #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset), .inst_valid(inst_valid), .inst(inst), .inst_PC(inst_PC),
        .inst_ready(inst_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .ALU_Operation(ALU_Operation), .funct3(funct3),
        .funct7(funct7), .ALU_ASrc(ALU_ASrc), .ALU_BSrc(ALU_BSrc), .branch_op(branch_op),
        .regRead_1(regRead_1), .regRead_2(regRead_2), .extend(extend), .PC(PC), .rd(rd),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .flush(flush),
        .illegal(illegal), .issued_count(issued_count), .report(report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] a, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [1:0] as, input logic bs, input logic br,
                                input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] ex,
                                input logic [19:0] pc, input logic [4:0] r, input logic rw,
                                input logic mr, input logic mw);
        exp_t e;
        e = '{a, f3, f7, as, bs, br, o1, o2, ex, pc, r, rw, mr, mw};
        return e;
    endfunction

    // Presents one word and holds it until accepted; expectation is queued unless flushed.
    task automatic applyStimulus(input logic [31:0] word, input logic [19:0] pc,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic fl,
                                 input exp_t e, output int waits, output logic ivAtAccept);
        logic got;
        got = 1'b0; waits = 0; ivAtAccept = 1'b0;
        inst = word; inst_PC = pc; rs1_data = d1; rs2_data = d2; flush = fl; inst_valid = 1'b1;
        while (!got && waits < 20) begin
            @(negedge clock);
            if (inst_ready) begin
                got = 1'b1;
                ivAtAccept = issue_valid;
            end else begin
                waits++;
            end
            @(posedge clock);
        end
        if (got && !fl) expQ.push_back(e);
        if (!got) begin
            vectors++; miscompares++;
            $display("[TB] FAIL accept-timeout: word %h not accepted within %0d cycles", word, waits);
        end
        #1;
        inst_valid = 1'b0;
        flush = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t obs, e;
        if (!reset && issue_valid && issue_ready) begin
            obs = '{ALU_Operation, funct3, funct7, ALU_ASrc, ALU_BSrc, branch_op, regRead_1,
                    regRead_2, extend, PC, rd, regWrite, memRead, memWrite};
            if (expQ.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL issue-extra: got slot %h expected no issue", obs);
            end else begin
                e = expQ.pop_front();
                checkOutput("issue-slot", obs, e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   w;
        logic iv;
        exp_t none;
        none = '0;

        reset = 1'b1; inst_valid = 1'b0; inst = 32'h002081B3; inst_PC = '0;
        rs1_data = '0; rs2_data = '0; issue_ready = 1'b1; flush = 1'b0; report = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset-inst_ready", 160'(inst_ready), 160'(1'b0));
        checkOutput("reset-rs_addr", 160'({rs1_addr, rs2_addr}), 160'({5'd1, 5'd2}));
        checkOutput("reset-state", 160'({issue_valid, illegal, issued_count, ALU_Operation, funct3,
                    funct7, ALU_ASrc, ALU_BSrc, branch_op, regRead_1, regRead_2, extend, PC, rd,
                    regWrite, memRead, memWrite}), 160'(0));
        reset = 1'b0;

        // ADD x3,x1,x2 accepted in the first cycle after reset, visible one cycle later.
        applyStimulus(32'h002081B3, 20'h00100, 32'd5, 32'd7, 1'b0,
                      mk(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 20'h00100, 5'd3, 1'b1, 1'b0, 1'b0), w, iv);
        checkOutput("first-accept-waits", 160'(w), 160'(0));
        checkOutput("latency-issue_valid", 160'(issue_valid), 160'(1'b1));

        // LW x5,8(x1) then dependent ADD x6,x5,x5: exactly one bubble.
        applyStimulus(32'h0080A283, 20'h00104, 32'h1000, 32'h77, 1'b0,
                      mk(3'b100, 3'b010, 7'h00, 2'b00, 1'b1, 1'b0, 32'h1000, 32'h77, 32'd8, 20'h00104, 5'd5, 1'b1, 1'b1, 1'b0), w, iv);
        applyStimulus(32'h00528333, 20'h00108, 32'h11, 32'h11, 1'b0,
                      mk(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'h11, 32'h11, 32'd0, 20'h00108, 5'd6, 1'b1, 1'b0, 1'b0), w, iv);
        checkOutput("load-use-stall-cycles", 160'(w), 160'(1));
        checkOutput("load-use-bubble", 160'(iv), 160'(1'b0));
        @(posedge clock); #1;
        checkOutput("count-after-load-use", 160'({issue_valid, issued_count}), 160'({1'b0, 32'd3}));

        // SRAI x8,x9,3 held for several cycles with execute stalled.
        issue_ready = 1'b0;
        applyStimulus(32'h4034D413, 20'h0010C, 32'h80000000, 32'h3, 1'b0,
                      mk(3'b001, 3'b101, 7'h20, 2'b00, 1'b1, 1'b0, 32'h80000000, 32'h3, 32'h403, 20'h0010C, 5'd8, 1'b1, 1'b0, 1'b0), w, iv);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("stall-hold", 160'({issue_valid, inst_ready, ALU_Operation, funct7, extend, issued_count}),
                        160'({1'b1, 1'b0, 3'b001, 7'h20, 32'h403, 32'd3}));
        end
        @(posedge clock); #1;
        issue_ready = 1'b1;

        // LUI x10,0x12345 accepted while SRAI issues; rs1 address forced to x0.
        inst = 32'h12345537;
        #1;
        checkOutput("lui-rs1_addr", 160'(rs1_addr), 160'(5'd0));
        applyStimulus(32'h12345537, 20'h00110, 32'hDEAD, 32'hBEEF, 1'b0,
                      mk(3'b110, 3'b101, 7'h00, 2'b00, 1'b1, 1'b0, 32'd0, 32'hBEEF, 32'h12345000, 20'h00110, 5'd10, 1'b1, 1'b0, 1'b0), w, iv);

        // JALR x1,-4(x2) with flush: dropped, while the LUI handshake still counts.
        applyStimulus(32'hFFC100E7, 20'h00114, 32'h2000, 32'h0, 1'b1, none, w, iv);
        checkOutput("flush-drop", 160'({issue_valid, issued_count}), 160'({1'b0, 32'd5}));

        // Full-throughput burst: JALR, SW, BEQ, ADD x0.
        applyStimulus(32'hFFC100E7, 20'h00200, 32'h2000, 32'h9, 1'b0,
                      mk(3'b011, 3'b000, 7'h00, 2'b10, 1'b1, 1'b0, 32'h2000, 32'h9, 32'hFFFFFFFC, 20'h00200, 5'd1, 1'b1, 1'b0, 1'b0), w, iv);
        applyStimulus(32'h0020A623, 20'h00204, 32'h3000, 32'h55, 1'b0,
                      mk(3'b101, 3'b010, 7'h00, 2'b00, 1'b1, 1'b0, 32'h3000, 32'h55, 32'd12, 20'h00204, 5'd0, 1'b0, 1'b0, 1'b1), w, iv);
        checkOutput("throughput-sw", 160'(w), 160'(0));
        applyStimulus(32'hFE208CE3, 20'h00208, 32'h1, 32'h1, 1'b0,
                      mk(3'b010, 3'b000, 7'h00, 2'b00, 1'b0, 1'b1, 32'h1, 32'h1, 32'hFFFFFFF8, 20'h00208, 5'd0, 1'b0, 1'b0, 1'b0), w, iv);
        checkOutput("throughput-beq", 160'(w), 160'(0));
        applyStimulus(32'h00208033, 20'h0020C, 32'h4, 32'h6, 1'b0,
                      mk(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'h4, 32'h6, 32'd0, 20'h0020C, 5'd0, 1'b0, 1'b0, 1'b0), w, iv);
        @(posedge clock); #1;
        checkOutput("count-after-burst", 160'({issue_valid, issued_count}), 160'({1'b0, 32'd9}));

        // Illegal word 0x00000000 becomes a NOP with a one-cycle illegal pulse.
        issue_ready = 1'b0;
        applyStimulus(32'h00000000, 20'h00300, 32'h44, 32'h55, 1'b0,
                      mk(3'b001, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 20'h00000, 5'd0, 1'b0, 1'b0, 1'b0), w, iv);
        checkOutput("illegal-pulse", 160'({illegal, issue_valid}), 160'({1'b1, 1'b1}));
        @(posedge clock); #1;
        checkOutput("illegal-clears", 160'({illegal, issue_valid, regWrite, ALU_Operation}),
                    160'({1'b0, 1'b1, 1'b0, 3'b001}));
        issue_ready = 1'b1;
        @(posedge clock); #1;

        // Reset while stalled discards the slot and clears the counter.
        issue_ready = 1'b0;
        applyStimulus(32'h002081B3, 20'h00400, 32'h1, 32'h2, 1'b0,
                      mk(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'h1, 32'h2, 32'd0, 20'h00400, 5'd3, 1'b1, 1'b0, 1'b0), w, iv);
        @(posedge clock); #1;
        reset = 1'b1;
        expQ.delete();
        @(posedge clock); #1;
        checkOutput("reset-mid-stall", 160'({issue_valid, inst_ready, issued_count}), 160'(0));
        reset = 1'b0;
        issue_ready = 1'b1;
        applyStimulus(32'h002081B3, 20'h00404, 32'h8, 32'h9, 1'b0,
                      mk(3'b000, 3'b000, 7'h00, 2'b00, 1'b0, 1'b0, 32'h8, 32'h9, 32'd0, 20'h00404, 5'd3, 1'b1, 1'b0, 1'b0), w, iv);
        checkOutput("accept-after-reset", 160'(w), 160'(0));
        @(posedge clock); #1;
        checkOutput("count-after-reset", 160'(issued_count), 160'(32'd1));

        checkOutput("queue-drained", 160'(expQ.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
